// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// master: requesters plus memory macro; slave: the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_arb_pick.sv
// Winner select between the two requesters.
// MEM_ARB_RR_EN defined: round-robin on contention (port other than last winner).
// MEM_ARB_RR_EN undefined: fixed priority, port 0 (CPU) always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt_c
);

`ifndef MEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    // One-hot winner; contention resolved by the configured policy.
    always_comb begin
        gnt_c = 2'b00;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            gnt_c = (last == PORT_CPU) ? 2'b10 : 2'b01;
`else
            gnt_c = 2'b01;
`endif
        end else if (req0) begin
            gnt_c = 2'b01;
        end else if (req1) begin
            gnt_c = 2'b10;
        end
    end

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU controller (port 0) and the
// loader/debug DMA (port 1). One command per cycle, fixed read latency
// tracking, per-port read-valid pulse on a shared rdata bus.
// Build option: MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             owner;
    logic             owner_nxt;
    logic             last;
    logic             last_nxt;
    logic [1:0]       pick_gnt_c;
    logic             win_c;
    logic             win_we_c;

    mem_arb_pick u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .last  (last),
        .gnt_c (pick_gnt_c)
    );

    assign win_c    = pick_gnt_c[1];
    assign win_we_c = win_c ? bus.we1 : bus.we0;

    // State, latency counter, read owner and last-granted pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= PORT_CPU;
            last  <= PORT_LOAD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    // Grant decode, memory command drive and read-return sequencing.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        owner_nxt     = owner;
        last_nxt      = last;
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.rvalid0   = 1'b0;
        bus.rvalid1   = 1'b0;
        bus.rdata     = '0;
        bus.busy      = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        case (state)
            IDLE: begin
                if (pick_gnt_c != 2'b00) begin
                    bus.gnt0      = ~win_c;
                    bus.gnt1      = win_c;
                    bus.mem_addr  = win_c ? bus.addr1 : bus.addr0;
                    bus.mem_wdata = win_c ? bus.wdata1 : bus.wdata0;
                    last_nxt      = win_c;
                    if (win_we_c) begin
                        bus.mem_write = 1'b1;
                    end else begin
                        bus.mem_read = 1'b1;
                        bus.busy     = 1'b1;
                        cnt_nxt      = CNT_W'(MEM_LAT);
                        owner_nxt    = win_c;
                        state_nxt    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                bus.busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    bus.rvalid0 = (owner == PORT_CPU);
                    bus.rvalid1 = (owner == PORT_LOAD);
                    bus.rdata   = bus.mem_rdata;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule : mem_port_arbiter
